// File: rtl/qnet_cmd_arb.sv
// Two-source (local / net) command arbiter feeding the QNET command FSM.
// Optional grant statistics are built when QNET_ARB_STATS_EN is defined.
module qnet_cmd_arb #(
  parameter int CMD_W       = 5,
  parameter int DT_W        = 32,
  parameter int TIMEOUT     = 1023,
  parameter int MAX_NET_RUN = 2
) (
  input  logic             st_clk_i,
  input  logic             st_rst_ni,
  input  logic             loc_req_i,
  input  logic [CMD_W-1:0] loc_cmd_i,
  input  logic [DT_W-1:0]  loc_dt_i,
  output logic             loc_ack_o,
  input  logic             net_req_i,
  input  logic [CMD_W-1:0] net_cmd_i,
  input  logic [DT_W-1:0]  net_dt_i,
  output logic             net_ack_o,
  output logic             ack_err_o,
  output logic             cmd_req_o,
  output logic             cmd_src_o,
  output logic [CMD_W-1:0] cmd_op_o,
  output logic [DT_W-1:0]  cmd_dt_o,
  input  logic             cmd_ack_i,
  input  logic             cmd_done_i,
  input  logic             clr_err_i,
  output logic             busy_o,
  output logic             err_o,
  output logic [1:0]       arb_st_o,
  output logic [15:0]      loc_cnt_o,
  output logic [15:0]      net_cnt_o
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_EXEC    = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  logic [1:0]    st_d;
  logic [TW-1:0] tmo_q;
  logic [1:0]    run_q;
  logic          loc_hold_q, net_hold_q;
  logic          loc_elig, net_elig, grant_loc, grant_net, grant;
  logic          tmo_hit, rel_ok, rel_err, rel;

  assign loc_elig  = loc_req_i & ~loc_hold_q;
  assign net_elig  = net_req_i & ~net_hold_q;
  // Net normally wins; local is forced through once net has run MAX_NET_RUN times.
  assign grant_loc = (arb_st_o == ST_IDLE) & loc_elig &
                     (~net_elig | (int'(run_q) >= MAX_NET_RUN));
  assign grant_net = (arb_st_o == ST_IDLE) & net_elig & ~grant_loc;
  assign grant     = grant_loc | grant_net;
  assign tmo_hit   = (tmo_q == TW'(TIMEOUT));
  assign rel       = rel_ok | rel_err;

  always_comb begin
    st_d    = arb_st_o;
    rel_ok  = 1'b0;
    rel_err = 1'b0;
    case (arb_st_o)
      ST_IDLE: if (grant) st_d = ST_ISSUE;
      ST_ISSUE: begin
        if (cmd_ack_i && cmd_done_i) begin
          st_d   = ST_RELEASE;
          rel_ok = 1'b1;
        end else if (tmo_hit) begin
          st_d    = ST_RELEASE;
          rel_err = 1'b1;
        end else if (cmd_ack_i) begin
          st_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (cmd_done_i) begin
          st_d   = ST_RELEASE;
          rel_ok = 1'b1;
        end else if (tmo_hit) begin
          st_d    = ST_RELEASE;
          rel_err = 1'b1;
        end
      end
      default: st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge st_clk_i or negedge st_rst_ni) begin
    if (!st_rst_ni) begin
      arb_st_o   <= ST_IDLE;
      cmd_req_o  <= 1'b0;
      busy_o     <= 1'b0;
      cmd_src_o  <= 1'b0;
      cmd_op_o   <= '0;
      cmd_dt_o   <= '0;
      tmo_q      <= '0;
      run_q      <= '0;
      loc_ack_o  <= 1'b0;
      net_ack_o  <= 1'b0;
      ack_err_o  <= 1'b0;
      err_o      <= 1'b0;
      loc_hold_q <= 1'b0;
      net_hold_q <= 1'b0;
    end else begin
      arb_st_o  <= st_d;
      cmd_req_o <= (st_d == ST_ISSUE);
      busy_o    <= (st_d != ST_IDLE);
      if (grant) begin
        cmd_src_o <= grant_net;
        cmd_op_o  <= grant_net ? net_cmd_i : loc_cmd_i;
        cmd_dt_o  <= grant_net ? net_dt_i  : loc_dt_i;
        tmo_q     <= '0;
      end else if ((arb_st_o == ST_ISSUE || arb_st_o == ST_EXEC) && !tmo_hit) begin
        tmo_q <= tmo_q + 1'b1;
      end
      if (grant_loc)
        run_q <= '0;
      else if (grant_net && loc_elig && run_q != 2'd3)
        run_q <= run_q + 2'd1;
      loc_ack_o <= rel & ~cmd_src_o;
      net_ack_o <= rel & cmd_src_o;
      ack_err_o <= rel_err;
      err_o     <= rel_err | (err_o & ~clr_err_i);
      // Holdoff is set on release only if the requester still holds req high.
      loc_hold_q <= (arb_st_o == ST_RELEASE && !cmd_src_o) ? loc_req_i : (loc_hold_q & loc_req_i);
      net_hold_q <= (arb_st_o == ST_RELEASE &&  cmd_src_o) ? net_req_i : (net_hold_q & net_req_i);
    end
  end

`ifdef QNET_ARB_STATS_EN
  always_ff @(posedge st_clk_i or negedge st_rst_ni) begin
    if (!st_rst_ni) begin
      loc_cnt_o <= '0;
      net_cnt_o <= '0;
    end else begin
      if (grant_loc && loc_cnt_o != 16'hFFFF) loc_cnt_o <= loc_cnt_o + 16'd1;
      if (grant_net && net_cnt_o != 16'hFFFF) net_cnt_o <= net_cnt_o + 16'd1;
    end
  end
`else
  assign loc_cnt_o = '0;
  assign net_cnt_o = '0;
`endif

endmodule

// File: tb/tb_qnet_cmd_arb.sv
// Directed bench for qnet_cmd_arb (TIMEOUT=15, MAX_NET_RUN=2).
module tb_qnet_cmd_arb;
  logic        st_clk_i = 1'b0;
  logic        st_rst_ni = 1'b0;
  logic        loc_req_i = 1'b0, net_req_i = 1'b0;
  logic [4:0]  loc_cmd_i = '0, net_cmd_i = '0;
  logic [31:0] loc_dt_i = '0, net_dt_i = '0;
  logic        cmd_ack_i = 1'b0, cmd_done_i = 1'b0, clr_err_i = 1'b0;
  logic        loc_ack_o, net_ack_o, ack_err_o, cmd_req_o, cmd_src_o, busy_o, err_o;
  logic [4:0]  cmd_op_o;
  logic [31:0] cmd_dt_o;
  logic [1:0]  arb_st_o;
  logic [15:0] loc_cnt_o, net_cnt_o;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  qnet_cmd_arb #(.CMD_W(5), .DT_W(32), .TIMEOUT(15), .MAX_NET_RUN(2)) dut (
    .st_clk_i(st_clk_i), .st_rst_ni(st_rst_ni),
    .loc_req_i(loc_req_i), .loc_cmd_i(loc_cmd_i), .loc_dt_i(loc_dt_i), .loc_ack_o(loc_ack_o),
    .net_req_i(net_req_i), .net_cmd_i(net_cmd_i), .net_dt_i(net_dt_i), .net_ack_o(net_ack_o),
    .ack_err_o(ack_err_o), .cmd_req_o(cmd_req_o), .cmd_src_o(cmd_src_o),
    .cmd_op_o(cmd_op_o), .cmd_dt_o(cmd_dt_o), .cmd_ack_i(cmd_ack_i), .cmd_done_i(cmd_done_i),
    .clr_err_i(clr_err_i), .busy_o(busy_o), .err_o(err_o), .arb_st_o(arb_st_o),
    .loc_cnt_o(loc_cnt_o), .net_cnt_o(net_cnt_o)
  );

  always #5 st_clk_i = ~st_clk_i;

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge st_clk_i);
      ok = cmd_req_o;
    end
  endtask

  task automatic test_reset;
    @(negedge st_clk_i);
    tot_cnt++;
    if ({cmd_req_o, loc_ack_o, net_ack_o, ack_err_o, busy_o, err_o, cmd_src_o, arb_st_o} !== 9'd0)
      $display("FAIL reset_ctl: got %b exp 0", {cmd_req_o, loc_ack_o, net_ack_o, ack_err_o, busy_o, err_o, cmd_src_o, arb_st_o});
    else pass_cnt++;
    tot_cnt++;
    if ({cmd_op_o, cmd_dt_o, loc_cnt_o, net_cnt_o} !== 69'd0)
      $display("FAIL reset_data: got %0h exp 0", {cmd_op_o, cmd_dt_o, loc_cnt_o, net_cnt_o});
    else pass_cnt++;
    st_rst_ni = 1'b1;
    @(negedge st_clk_i);
  endtask

  task automatic test_local;
    loc_req_i = 1'b1; loc_cmd_i = 5'd3; loc_dt_i = 32'hA5A5A5A5;
    @(negedge st_clk_i);
    tot_cnt++;
    if ({cmd_req_o, busy_o, arb_st_o} !== 4'b1101)
      $display("FAIL local_grant: got %b exp 1101", {cmd_req_o, busy_o, arb_st_o});
    else pass_cnt++;
    tot_cnt++;
    if ({cmd_src_o, cmd_op_o, cmd_dt_o} !== {1'b0, 5'd3, 32'hA5A5A5A5})
      $display("FAIL local_latch: got %0h exp %0h", {cmd_src_o, cmd_op_o, cmd_dt_o}, {1'b0, 5'd3, 32'hA5A5A5A5});
    else pass_cnt++;
    loc_dt_i = 32'h12345678; loc_cmd_i = 5'd9;
    @(negedge st_clk_i);
    cmd_ack_i = 1'b1;
    @(negedge st_clk_i);
    cmd_ack_i = 1'b0;
    tot_cnt++;
    if ({cmd_req_o, arb_st_o} !== 3'b010)
      $display("FAIL local_exec: got %b exp 010", {cmd_req_o, arb_st_o});
    else pass_cnt++;
    repeat (4) @(negedge st_clk_i);
    cmd_done_i = 1'b1;
    @(negedge st_clk_i);
    cmd_done_i = 1'b0;
    tot_cnt++;
    if ({loc_ack_o, net_ack_o, ack_err_o, arb_st_o} !== 5'b10011)
      $display("FAIL local_ack: got %b exp 10011", {loc_ack_o, net_ack_o, ack_err_o, arb_st_o});
    else pass_cnt++;
    tot_cnt++;
    if ({cmd_op_o, cmd_dt_o} !== {5'd3, 32'hA5A5A5A5})
      $display("FAIL local_hold_payload: got %0h exp %0h", {cmd_op_o, cmd_dt_o}, {5'd3, 32'hA5A5A5A5});
    else pass_cnt++;
    loc_req_i = 1'b0;
    @(negedge st_clk_i);
    tot_cnt++;
    if ({loc_ack_o, busy_o, arb_st_o} !== 4'b0000)
      $display("FAIL local_idle: got %b exp 0000", {loc_ack_o, busy_o, arb_st_o});
    else pass_cnt++;
  endtask

  task automatic test_starvation;
    bit ok;
    bit exp_src [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    loc_req_i = 1'b1; net_req_i = 1'b1; loc_cmd_i = 5'd1; net_cmd_i = 5'd2;
    for (int i = 0; i < 6; i++) begin
      wait_req(ok);
      tot_cnt++;
      if (!ok || cmd_src_o !== exp_src[i])
        $display("FAIL arb_order[%0d]: got req=%b src=%b exp src=%b", i, ok, cmd_src_o, exp_src[i]);
      else pass_cnt++;
      cmd_ack_i = 1'b1; cmd_done_i = 1'b1;
      @(negedge st_clk_i);
      cmd_ack_i = 1'b0; cmd_done_i = 1'b0;
      tot_cnt++;
      if ({loc_ack_o, net_ack_o, arb_st_o} !== {~exp_src[i], exp_src[i], 2'd3})
        $display("FAIL arb_ack[%0d]: got %b exp %b", i, {loc_ack_o, net_ack_o, arb_st_o}, {~exp_src[i], exp_src[i], 2'd3});
      else pass_cnt++;
      if (i == 5) begin
        loc_req_i = 1'b0; net_req_i = 1'b0;
      end else if (exp_src[i]) net_req_i = 1'b0;
      else loc_req_i = 1'b0;
      @(negedge st_clk_i);
      if (i != 5) begin
        loc_req_i = 1'b1; net_req_i = 1'b1;
      end
    end
    @(negedge st_clk_i);
  endtask

  task automatic test_timeout;
    loc_req_i = 1'b1; loc_cmd_i = 5'd7;
    @(negedge st_clk_i);
    tot_cnt++;
    if (cmd_req_o !== 1'b1) $display("FAIL tmo_grant: got %b exp 1", cmd_req_o);
    else pass_cnt++;
    repeat (15) @(negedge st_clk_i);
    tot_cnt++;
    if ({loc_ack_o, arb_st_o} !== 3'b001)
      $display("FAIL tmo_early: got %b exp 001", {loc_ack_o, arb_st_o});
    else pass_cnt++;
    @(negedge st_clk_i);
    tot_cnt++;
    if ({loc_ack_o, ack_err_o, err_o} !== 3'b111)
      $display("FAIL tmo_fire: got %b exp 111", {loc_ack_o, ack_err_o, err_o});
    else pass_cnt++;
    loc_req_i = 1'b0;
    @(negedge st_clk_i);
    tot_cnt++;
    if ({loc_ack_o, ack_err_o, err_o} !== 3'b001)
      $display("FAIL tmo_sticky: got %b exp 001", {loc_ack_o, ack_err_o, err_o});
    else pass_cnt++;
    clr_err_i = 1'b1;
    @(negedge st_clk_i);
    clr_err_i = 1'b0;
    tot_cnt++;
    if (err_o !== 1'b0) $display("FAIL tmo_clr: got %b exp 0", err_o);
    else pass_cnt++;
    // Net timeout while clr_err_i is held on the firing edge.
    net_req_i = 1'b1;
    @(negedge st_clk_i);
    repeat (15) @(negedge st_clk_i);
    clr_err_i = 1'b1;
    @(negedge st_clk_i);
    clr_err_i = 1'b0;
    tot_cnt++;
    if ({net_ack_o, loc_ack_o, ack_err_o, err_o} !== 4'b1011)
      $display("FAIL tmo_set_wins: got %b exp 1011", {net_ack_o, loc_ack_o, ack_err_o, err_o});
    else pass_cnt++;
    net_req_i = 1'b0;
    @(negedge st_clk_i);
    clr_err_i = 1'b1;
    @(negedge st_clk_i);
    clr_err_i = 1'b0;
    // Done on the timeout edge reports ok.
    loc_req_i = 1'b1;
    @(negedge st_clk_i);
    cmd_ack_i = 1'b1;
    @(negedge st_clk_i);
    cmd_ack_i = 1'b0;
    repeat (14) @(negedge st_clk_i);
    cmd_done_i = 1'b1;
    @(negedge st_clk_i);
    cmd_done_i = 1'b0;
    tot_cnt++;
    if ({loc_ack_o, ack_err_o, err_o} !== 3'b100)
      $display("FAIL tmo_done_wins: got %b exp 100", {loc_ack_o, ack_err_o, err_o});
    else pass_cnt++;
    loc_req_i = 1'b0;
    @(negedge st_clk_i);
  endtask

  task automatic test_holdoff_reset;
    bit ok;
    bit seen;
    loc_req_i = 1'b1;
    wait_req(ok);
    cmd_ack_i = 1'b1; cmd_done_i = 1'b1;
    @(negedge st_clk_i);
    cmd_ack_i = 1'b0; cmd_done_i = 1'b0;
    tot_cnt++;
    if (loc_ack_o !== 1'b1 || !ok) $display("FAIL hold_ack: got %b exp 1", loc_ack_o);
    else pass_cnt++;
    repeat (4) @(negedge st_clk_i);
    tot_cnt++;
    if ({cmd_req_o, busy_o, arb_st_o} !== 4'b0000)
      $display("FAIL hold_block: got %b exp 0000", {cmd_req_o, busy_o, arb_st_o});
    else pass_cnt++;
    loc_req_i = 1'b0;
    @(negedge st_clk_i);
    loc_req_i = 1'b1;
    @(negedge st_clk_i);
    tot_cnt++;
    if (cmd_req_o !== 1'b1) $display("FAIL hold_regrant: got %b exp 1", cmd_req_o);
    else pass_cnt++;
    cmd_ack_i = 1'b1;
    @(negedge st_clk_i);
    cmd_ack_i = 1'b0;
    loc_req_i = 1'b0;
    #2 st_rst_ni = 1'b0;
    #1;
    tot_cnt++;
    if ({cmd_req_o, busy_o, arb_st_o, err_o, cmd_op_o} !== 10'd0)
      $display("FAIL rst_async: got %b exp 0", {cmd_req_o, busy_o, arb_st_o, err_o, cmd_op_o});
    else pass_cnt++;
    @(negedge st_clk_i);
    st_rst_ni = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(negedge st_clk_i);
      seen |= loc_ack_o | net_ack_o;
    end
    tot_cnt++;
    if (seen !== 1'b0) $display("FAIL rst_no_ack: got %b exp 0", seen);
    else pass_cnt++;
  endtask

  task automatic run_one(input bit src);
    bit ok;
    if (src) net_req_i = 1'b1; else loc_req_i = 1'b1;
    wait_req(ok);
    tot_cnt++;
    if (!ok || cmd_src_o !== src) $display("FAIL stats_grant: got req=%b src=%b exp src=%b", ok, cmd_src_o, src);
    else pass_cnt++;
    cmd_ack_i = 1'b1; cmd_done_i = 1'b1;
    @(negedge st_clk_i);
    cmd_ack_i = 1'b0; cmd_done_i = 1'b0;
    loc_req_i = 1'b0; net_req_i = 1'b0;
    @(negedge st_clk_i);
  endtask

  task automatic test_stats;
    logic [31:0] exp;
    for (int i = 0; i < 3; i++) run_one(1'b0);
    for (int i = 0; i < 4; i++) run_one(1'b1);
`ifdef QNET_ARB_STATS_EN
    exp = {16'd3, 16'd4};
`else
    exp = 32'd0;
`endif
    tot_cnt++;
    if ({loc_cnt_o, net_cnt_o} !== exp)
      $display("FAIL stats_cnt: got %0h exp %0h", {loc_cnt_o, net_cnt_o}, exp);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_local();
    test_starvation();
    test_timeout();
    test_holdoff_reset();
    test_stats();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
